// File: rtl/fsm_sched_pkg.sv
// Shared definitions for the burst scheduler.
//   - state_e : scheduler states (IDLE, DRST, STREAM, DRAIN, FIN)
//   - NREQ    : number of requesters sharing the datapath
//   - SYM_W   : width of one datapath symbol
//   - idx2onehot : requester index -> one-hot grant vector
package fsm_sched_pkg;

    localparam int NREQ  = 2;
    localparam int SYM_W = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRST   = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        FIN    = 3'd4
    } state_e;

    function automatic logic [NREQ-1:0] idx2onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fsm_burst_sched_rr_arb2.sv
// Two-way round-robin arbiter used by fsm_burst_sched.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (pointer -> 0)
//   req_i[1:0]  : request vector
//   update_i    : commit the current grant; pointer moves to the other index
//   grant_o[1:0]: combinational one-hot grant, 0 when no request
module rr_arb2
    import fsm_sched_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req_i,
    input  logic            update_i,
    output logic [NREQ-1:0] grant_o
);

    logic ptr_q;
    logic ptr_d;
    logic win_idx;

    always_comb begin
        // The pointer index wins whenever it is requesting; otherwise the other one.
        win_idx = req_i[ptr_q] ? ptr_q : ~ptr_q;
        grant_o = (|req_i) ? idx2onehot(win_idx) : '0;
        ptr_d   = ptr_q;
        if (update_i && (|req_i)) begin
            ptr_d = ~win_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fsm_burst_sched.sv
// Burst scheduler sharing one 2-bit-in / 1-bit-out sequential datapath
// between two requesters. Each burst: reset the datapath for RST_CYC cycles,
// stream the owner's symbols one per clock, count 1s on dut_y, report
// ones_cnt/err with a one-cycle done pulse.
// Optional feature macro: FSM_BURST_SCHED_TRACE_EN adds y_trace[15:0], the
// last 16 captured dut_y samples (newest in bit 0), cleared at grant.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req[1:0]        : per-requester burst request (held until done)
//   sym_data[3:0]   : [1:0] requester 0 symbol, [3:2] requester 1 symbol
//   sym_valid[1:0]  : per-requester symbol valid
//   sym_last[1:0]   : per-requester last flag, qualified by valid
//   sym_ready[1:0]  : accept, only the owner's bit during STREAM
//   grant[1:0]      : one-hot owner, 0 when idle
//   dut_rstn        : datapath reset, active-low
//   dut_x[1:0]      : datapath input
//   dut_y           : datapath output
//   done[1:0]       : one-cycle pulse to the owner at burst end
//   ones_cnt[CW-1:0]: number of 1s seen on dut_y during the burst
//   err             : burst aborted (bubble or MAX_LEN without last)
module fsm_burst_sched
    import fsm_sched_pkg::*;
#(
    parameter int MAX_LEN = 64,
    parameter int RST_CYC = 2,
    parameter int DUT_LAT = 1,
    parameter int CW      = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*SYM_W-1:0] sym_data,
    input  logic [NREQ-1:0]       sym_valid,
    input  logic [NREQ-1:0]       sym_last,
    output logic [NREQ-1:0]       sym_ready,
    output logic [NREQ-1:0]       grant,
    output logic                  dut_rstn,
    output logic [SYM_W-1:0]      dut_x,
    input  logic                  dut_y,
    output logic [NREQ-1:0]       done,
    output logic [CW-1:0]         ones_cnt,
    output logic                  err
`ifdef FSM_BURST_SCHED_TRACE_EN
    ,
    output logic [15:0]           y_trace
`endif
);

    localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    // Bit of the tag pipeline whose value is leaving this cycle.
    localparam logic [DUT_LAT-1:0] TAG_EXIT = DUT_LAT'(1) << (DUT_LAT - 1);

    state_e              state_q;
    logic                owner_q;
    logic [NREQ-1:0]     grant_q;
    logic [NREQ-1:0]     sym_ready_q;
    logic [NREQ-1:0]     done_q;
    logic                err_q;
    logic [CW-1:0]       ones_q;
    logic [CW-1:0]       scnt_q;
    logic [RCW-1:0]      rcnt_q;
    logic [SYM_W-1:0]    dut_x_q;
    logic                dut_rstn_q;
    logic [DUT_LAT-1:0]  tag_q;
`ifdef FSM_BURST_SCHED_TRACE_EN
    logic [15:0]         trace_q;
`endif

    logic [NREQ-1:0]     arb_grant;
    logic                arb_update;
    logic [SYM_W-1:0]    owner_sym;
    logic                owner_valid;
    logic                owner_last;
    logic                accept;
    logic                hit_max;
    logic                smp;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req),
        .update_i (arb_update),
        .grant_o  (arb_grant)
    );

    always_comb begin
        arb_update  = (state_q == IDLE);
        owner_sym   = owner_q ? sym_data[3:2] : sym_data[1:0];
        owner_valid = sym_valid[owner_q];
        owner_last  = sym_last[owner_q];
        accept      = (state_q == STREAM) && owner_valid;
        // This accept would be symbol number MAX_LEN.
        hit_max     = (scnt_q == CW'(MAX_LEN - 1));
        smp         = tag_q[DUT_LAT-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            grant_q     <= '0;
            sym_ready_q <= '0;
            done_q      <= '0;
            err_q       <= 1'b0;
            ones_q      <= '0;
            scnt_q      <= '0;
            rcnt_q      <= '0;
            dut_x_q     <= '0;
            dut_rstn_q  <= 1'b0;
            tag_q       <= '0;
`ifdef FSM_BURST_SCHED_TRACE_EN
            trace_q     <= '0;
`endif
        end else begin
            done_q <= '0;
            // Each driven symbol carries a tag; dut_y is sampled as it exits.
            tag_q  <= (tag_q << 1) | DUT_LAT'(accept);
            if (smp && dut_y && (ones_q != CW'(MAX_LEN))) begin
                ones_q <= ones_q + 1'b1;
            end
`ifdef FSM_BURST_SCHED_TRACE_EN
            if (smp) begin
                trace_q <= {trace_q[14:0], dut_y};
            end
`endif
            unique case (state_q)
                IDLE: begin
                    dut_rstn_q <= 1'b1;
                    dut_x_q    <= '0;
                    if (|req) begin
                        grant_q    <= arb_grant;
                        owner_q    <= arb_grant[1];
                        ones_q     <= '0;
                        err_q      <= 1'b0;
                        scnt_q     <= '0;
                        rcnt_q     <= '0;
                        dut_rstn_q <= 1'b0;
`ifdef FSM_BURST_SCHED_TRACE_EN
                        trace_q    <= '0;
`endif
                        state_q    <= DRST;
                    end
                end
                DRST: begin
                    if (rcnt_q == RCW'(RST_CYC - 1)) begin
                        dut_rstn_q  <= 1'b1;
                        sym_ready_q <= grant_q;
                        state_q     <= STREAM;
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                end
                STREAM: begin
                    if (owner_valid) begin
                        dut_x_q <= owner_sym;
                        scnt_q  <= scnt_q + 1'b1;
                        if (owner_last || hit_max) begin
                            sym_ready_q <= '0;
                            state_q     <= DRAIN;
                            if (!owner_last) begin
                                err_q <= 1'b1;
                            end
                        end
                    end else begin
                        // The datapath cannot be paused, so a gap ends the burst.
                        err_q       <= 1'b1;
                        sym_ready_q <= '0;
                        state_q     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Leave once only the exiting tag (if any) remains in flight.
                    if ((tag_q & ~TAG_EXIT) == '0) begin
                        done_q  <= grant_q;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    grant_q <= '0;
                    dut_x_q <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign sym_ready = sym_ready_q;
    assign grant     = grant_q;
    assign dut_rstn  = dut_rstn_q;
    assign dut_x     = dut_x_q;
    assign done      = done_q;
    assign ones_cnt  = ones_q;
    assign err       = err_q;
`ifdef FSM_BURST_SCHED_TRACE_EN
    assign y_trace   = trace_q;
`endif

endmodule

// File: tb/tb_fsm_burst_sched.sv
// Directed bench for fsm_burst_sched (MAX_LEN=4, RST_CYC=2, DUT_LAT=1).
// The shared datapath is a small FSM: state s <= x each clock (cleared while
// dut_rstn is low), y = x[0] ^ s[0]; expected ones counts are worked out by hand.
module tb_fsm_burst_sched;

    localparam int TB_MAX = 4;
    localparam int TB_CW  = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req;
    logic [3:0]        sym_data;
    logic [1:0]        sym_valid;
    logic [1:0]        sym_last;
    logic [1:0]        sym_ready;
    logic [1:0]        grant;
    logic              dut_rstn;
    logic [1:0]        dut_x;
    logic              dut_y;
    logic [1:0]        done;
    logic [TB_CW-1:0]  ones_cnt;
    logic              err;
`ifdef FSM_BURST_SCHED_TRACE_EN
    logic [15:0]       y_trace;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    logic [1:0] syms [0:7];

    always #5 clk = ~clk;

    fsm_burst_sched #(
        .MAX_LEN (TB_MAX),
        .RST_CYC (2),
        .DUT_LAT (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .sym_data  (sym_data),
        .sym_valid (sym_valid),
        .sym_last  (sym_last),
        .sym_ready (sym_ready),
        .grant     (grant),
        .dut_rstn  (dut_rstn),
        .dut_x     (dut_x),
        .dut_y     (dut_y),
        .done      (done),
        .ones_cnt  (ones_cnt),
        .err       (err)
`ifdef FSM_BURST_SCHED_TRACE_EN
        ,
        .y_trace   (y_trace)
`endif
    );

    // Shared datapath model.
    logic [1:0] fsm_s;
    always_ff @(posedge clk) begin
        if (!dut_rstn) fsm_s <= 2'b00;
        else           fsm_s <= dut_x;
    end
    assign dut_y = dut_x[0] ^ fsm_s[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        $display("check %-14s got %0d expected %0d", tag, obs, exp);
    endtask

    // Runs one burst for requester r from IDLE; caller sets req beforehand.
    task automatic do_burst(input int r, input int n, input int bub, input bit use_last,
                            input bit drop, input int exp_acc, input int exp_ones,
                            input bit exp_err, input string nm);
        int waited;
        int rlow;
        int acc;
        logic [1:0] g_seen;
        waited = 0; rlow = 0; acc = 0; g_seen = 2'b00;
        while (!sym_ready[r] && waited < 30) begin
            if (grant != 2'b00 && g_seen == 2'b00) g_seen = grant;
            if (grant != 2'b00 && !dut_rstn) rlow++;
            @(negedge clk);
            waited++;
        end
        chk({nm, ".ready_to"}, 32'(waited < 30), 1);
        chk({nm, ".grant"}, g_seen, 32'(1 << r));
        chk({nm, ".rstn_low"}, rlow, 2);
        for (int i = 0; i < n; i++) begin
            if (!sym_ready[r]) break;
            sym_valid[r] = (i != bub);
            sym_data[2*r +: 2] = syms[i];
            sym_last[r] = use_last && (i == n - 1);
            @(negedge clk);
            if (i != bub) begin
                acc++;
                chk({nm, ".dut_x"}, dut_x, syms[i]);
            end
        end
        sym_valid = 2'b00;
        sym_last  = 2'b00;
        chk({nm, ".accepted"}, acc, exp_acc);
        chk({nm, ".ready_lo"}, sym_ready, 0);
        waited = 0;
        while (done == 2'b00 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk({nm, ".done"}, done, 32'(1 << r));
        chk({nm, ".ones"}, ones_cnt, exp_ones);
        chk({nm, ".err"}, err, exp_err);
        if (drop) req[r] = 1'b0;
        @(negedge clk);
        chk({nm, ".done_1cy"}, done, 0);
        chk({nm, ".grant_clr"}, grant, 0);
        chk({nm, ".ones_hold"}, ones_cnt, exp_ones);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 2'b00; sym_data = 4'h0; sym_valid = 2'b00; sym_last = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst.grant", grant, 0);
        chk("rst.ready", sym_ready, 0);
        chk("rst.done", done, 0);
        chk("rst.err", err, 0);
        chk("rst.ones", ones_cnt, 0);
        chk("rst.dut_x", dut_x, 0);
        chk("rst.dut_rstn", dut_rstn, 0);
        rst = 1'b0;

        // T1: 00,01,10,11 -> y = 0,1,1,1
        syms[0] = 2'd0; syms[1] = 2'd1; syms[2] = 2'd2; syms[3] = 2'd3;
        req = 2'b01;
        do_burst(0, 4, -1, 1'b1, 1'b1, 4, 3, 1'b0, "t1");
`ifdef FSM_BURST_SCHED_TRACE_EN
        chk("t1.y_trace", y_trace, 32'h0007);
`endif

        // Pointer back to 0 so the conflict goes to requester 0 first.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // T2: both requesting -> 0, 1, 0
        req = 2'b11;
        syms[0] = 2'd1; syms[1] = 2'd1; syms[2] = 2'd0;   // y = 1,0,1
        do_burst(0, 3, -1, 1'b1, 1'b0, 3, 2, 1'b0, "t2a");
        syms[0] = 2'd3; syms[1] = 2'd2; syms[2] = 2'd2;   // y = 1,1,0
        do_burst(1, 3, -1, 1'b1, 1'b1, 3, 2, 1'b0, "t2b");
        syms[0] = 2'd2; syms[1] = 2'd3; syms[2] = 2'd3;   // y = 0,1,0
        do_burst(0, 3, -1, 1'b1, 1'b1, 3, 1, 1'b0, "t2c");

        // T3: bubble on the 2nd symbol -> only symbol 0 (y = 1) counted, err
        req = 2'b01;
        syms[0] = 2'd1; syms[1] = 2'd2; syms[2] = 2'd3; syms[3] = 2'd0; syms[4] = 2'd1;
        do_burst(0, 5, 1, 1'b1, 1'b1, 1, 1, 1'b1, "t3");

        // T4: 6 symbols without last, MAX_LEN=4 -> 4 accepted, y = 1,1,1,1, err
        req = 2'b10;
        syms[0] = 2'd1; syms[1] = 2'd0; syms[2] = 2'd1; syms[3] = 2'd0; syms[4] = 2'd1; syms[5] = 2'd0;
        do_burst(1, 6, -1, 1'b0, 1'b1, 4, 4, 1'b1, "t4");

        // T4b: exactly MAX_LEN symbols with last -> no err, no ones
        req = 2'b01;
        syms[0] = 2'd0; syms[1] = 2'd0; syms[2] = 2'd0; syms[3] = 2'd0;
        do_burst(0, 4, -1, 1'b1, 1'b1, 4, 0, 1'b0, "t4b");

        // T5: reset during STREAM, then a fresh burst
        req = 2'b01;
        for (int w = 0; w < 30 && !sym_ready[0]; w++) @(negedge clk);
        chk("t5.in_stream", sym_ready, 1);
        sym_valid[0] = 1'b1; sym_data[1:0] = 2'd2;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5.grant", grant, 0);
        chk("t5.dut_rstn", dut_rstn, 0);
        chk("t5.ready", sym_ready, 0);
        chk("t5.done", done, 0);
        chk("t5.ones", ones_cnt, 0);
        sym_valid = 2'b00;
        rst = 1'b0;
        syms[0] = 2'd3; syms[1] = 2'd1;   // y = 1,0
        do_burst(0, 2, -1, 1'b1, 1'b1, 2, 1, 1'b0, "t5r");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
